// File: rtl/gusn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gusn_ctrl_pkg
// Description : Shared types and constants for the frame sequencer around net_proc.
// Revision    : 1.0 - initial release
// ============================================================================
package gusn_ctrl_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_START = 3'd2,
        SEQ_RUN   = 3'd3,
        SEQ_SEND  = 3'd4,
        SEQ_ABORT = 3'd5
    } seq_state_t;

    localparam int         FRAME_LEN_MNIST = 784;
    localparam logic [7:0] ASCII_DIGIT0    = 8'h30;
    localparam logic [7:0] ASCII_QMARK     = 8'h3F;

    // Plain 8-bit wrap-around add; out-of-range indices simply map past '9'.
    function automatic logic [7:0] digit_char(input logic [7:0] base, input logic [3:0] idx);
        return base + {4'h0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rise_edge.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge
// Description : Rising-edge detector; pulse is high in the first cycle the level is high.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_edge (
    input  logic clk,
    input  logic nRST,
    input  logic level,
    output logic pulse
);

    logic r_level_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level;
        end
    end

    assign pulse = level && !r_level_q;

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : Loads UART bytes into net_proc image memory, starts inference
//               and queues the resulting ASCII digit (or '?' on abort) to uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer
    import gusn_ctrl_pkg::*;
#(
    parameter int         FRAME_LEN      = FRAME_LEN_MNIST,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] ASCII_BASE     = ASCII_DIGIT0,
    parameter logic [7:0] ERR_CHAR       = ASCII_QMARK
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic       mem_rst,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic       net_start,
    input  logic       net_done,
    input  logic [3:0] net_result,
    output logic       tx_rq,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [3:0] last_result,
    output logic       overrun,
    output logic       frame_err
);

    localparam int                  c_CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int                  c_TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0]  c_FRAME_LEN = c_CNT_W'(FRAME_LEN);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit                  c_TO_EN     = (TIMEOUT_CYCLES > 0);

    seq_state_t           r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_TO_W-1:0]    r_to;
    logic                 r_wr_pend;
    logic [7:0]           r_byte;
    logic [7:0]           r_char;

    logic w_byte_evt;
    logic w_err_rise;
    logic w_done_rise;
    logic w_loading;
    logic w_err_abort;
    logic w_to_abort;
    logic w_abort;
    logic w_accept;

    rise_edge u_rx_edge   (.clk(clk), .nRST(nRST), .level(rx_ready), .pulse(w_byte_evt));
    rise_edge u_err_edge  (.clk(clk), .nRST(nRST), .level(rx_error), .pulse(w_err_rise));
    rise_edge u_done_edge (.clk(clk), .nRST(nRST), .level(net_done), .pulse(w_done_rise));

    // Once the frame is full the last write is still in flight; aborts no longer apply.
    assign w_loading   = (r_state == SEQ_LOAD) && (r_count < c_FRAME_LEN);
    assign w_err_abort = w_loading && w_err_rise;
    assign w_to_abort  = c_TO_EN && w_loading && !w_byte_evt && (r_to == c_TO_LAST);
    assign w_abort     = w_err_abort || w_to_abort;
    assign w_accept    = w_byte_evt && !w_err_abort && ((r_state == SEQ_IDLE) || w_loading);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= SEQ_IDLE;
            r_count     <= '0;
            r_to        <= '0;
            r_wr_pend   <= 1'b0;
            r_byte      <= 8'h00;
            r_char      <= 8'h00;
            mem_rst     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'h00;
            net_start   <= 1'b0;
            tx_rq       <= 1'b0;
            tx_data     <= 8'h00;
            last_result <= 4'hF;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            mem_rst   <= 1'b0;
            net_start <= 1'b0;
            tx_rq     <= 1'b0;
            frame_err <= 1'b0;

            // Bytes are staged one cycle so mem_rst of a new frame precedes its first write.
            mem_we    <= r_wr_pend && !w_abort;
            if (r_wr_pend && !w_abort) begin
                mem_wdata <= r_byte;
            end
            r_wr_pend <= w_accept;
            if (w_accept) begin
                r_byte <= rx_data;
            end

            if (w_byte_evt && ((r_state == SEQ_RUN) || (r_state == SEQ_SEND))) begin
                overrun <= 1'b1;
            end

            if (w_byte_evt || (r_state != SEQ_LOAD)) begin
                r_to <= '0;
            end else if (r_to != c_TO_LAST) begin
                r_to <= r_to + 1'b1;
            end

            case (r_state)
                SEQ_IDLE: begin
                    if (w_accept) begin
                        mem_rst <= 1'b1;
                        r_count <= c_CNT_W'(1);
                        r_state <= SEQ_LOAD;
                    end
                end
                SEQ_LOAD: begin
                    if (w_abort) begin
                        frame_err <= 1'b1;
                        r_count   <= '0;
                        r_state   <= SEQ_ABORT;
                    end else begin
                        if (w_accept) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (mem_we && (r_count == c_FRAME_LEN)) begin
                            net_start <= 1'b1;
                            r_state   <= SEQ_START;
                        end
                    end
                end
                SEQ_START: begin
                    r_count <= '0;
                    r_state <= SEQ_RUN;
                end
                SEQ_RUN: begin
                    if (w_done_rise) begin
                        last_result <= net_result;
                        r_char      <= digit_char(ASCII_BASE, net_result);
                        r_state     <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (!tx_busy) begin
                        tx_rq   <= 1'b1;
                        tx_data <= r_char;
                        r_state <= SEQ_IDLE;
                    end
                end
                SEQ_ABORT: begin
                    r_char  <= ERR_CHAR;
                    r_state <= SEQ_SEND;
                end
                default: begin
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sequencer
// Description : Directed self-checking bench for frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_error = 1'b0;
    logic       net_done = 1'b0;
    logic [3:0] net_result = 4'h0;
    logic       tx_busy = 1'b0;
    logic       mem_rst, mem_we, net_start, tx_rq, overrun, frame_err;
    logic [7:0] mem_wdata, tx_data;
    logic [3:0] last_result;

    frame_sequencer #(.FRAME_LEN(784), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .nRST(nRST), .rx_ready(rx_ready), .rx_data(rx_data), .rx_error(rx_error),
        .mem_rst(mem_rst), .mem_we(mem_we), .mem_wdata(mem_wdata), .net_start(net_start),
        .net_done(net_done), .net_result(net_result), .tx_rq(tx_rq), .tx_data(tx_data),
        .tx_busy(tx_busy), .last_result(last_result), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0, rst_cnt = 0, we_cnt = 0, ns_cnt = 0, tx_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int last_rst_cyc = -1, last_we_cyc = -1, ns_cyc = -1, tx_cyc = -1, fe_cyc = -1;
    int ev_cyc = 0;
    int tests = 0, fails = 0;
    logic [7:0] tx_last = 8'h00;
    logic [7:0] we_log [0:4095];

    // Output monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (mem_rst) begin rst_cnt++; last_rst_cyc = cyc; end
        if (mem_we) begin
            if (we_cnt < 4096) we_log[we_cnt] = mem_wdata;
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (mem_rst && mem_we) both_cnt++;
        if (net_start) begin ns_cnt++; ns_cyc = cyc; end
        if (tx_rq) begin tx_cnt++; tx_cyc = cyc; tx_last = tx_data; end
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        ev_cyc   = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_tx(input int prev, input string tag);
        int k = 0;
        while (tx_cnt == prev && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tx_cnt != prev), 32'd1);
    endtask

    task automatic wait_fe(input int prev, input string tag);
        int k = 0;
        while (fe_cnt == prev && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(fe_cnt != prev), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ev, m, f, e, we0, fe0, tx0, r0, errs;

        // Reset state
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst mem_rst", 32'(mem_rst), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst net_start", 32'(net_start), 32'd0);
        chk("rst tx_rq", 32'(tx_rq), 32'd0);
        chk("rst frame_err", 32'(frame_err), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst last_result", 32'(last_result), 32'hF);

        // Full frame, 20-cycle gaps
        first_ev = 0;
        for (int i = 0; i < 784; i++) begin
            send_byte(8'(i & 15), 20);
            if (i == 0) first_ev = ev_cyc;
        end
        errs = 0;
        for (int i = 0; i < 784; i++) if (we_log[i] !== 8'(i & 15)) errs++;
        chk("frame mem_rst count", 32'(rst_cnt), 32'd1);
        chk("frame mem_rst timing", 32'(last_rst_cyc), 32'(first_ev + 1));
        chk("frame mem_we count", 32'(we_cnt), 32'd784);
        chk("frame data errors", 32'(errs), 32'd0);
        chk("frame last write timing", 32'(last_we_cyc), 32'(ev_cyc + 2));
        chk("frame net_start count", 32'(ns_cnt), 32'd1);
        chk("frame net_start timing", 32'(ns_cyc), 32'(last_we_cyc + 1));

        // Byte during RUN, then result 7
        send_byte(8'hAA, 3);
        chk("run byte dropped", 32'(we_cnt), 32'd784);
        chk("run overrun", 32'(overrun), 32'd1);
        tx0 = tx_cnt;
        @(negedge clk);
        net_result = 4'd7;
        net_done   = 1'b1;
        m = cyc;
        wait_tx(tx0, "result7 tx_rq seen");
        chk("result7 tx timing", 32'(tx_cyc), 32'(m + 2));
        chk("result7 tx_data", 32'(tx_last), 32'h37);
        chk("result7 last_result", 32'(last_result), 32'd7);
        repeat (5) @(negedge clk);
        chk("result7 single tx_rq", 32'(tx_cnt), 32'(tx0 + 1));
        net_done = 1'b0;

        // Second frame, tx_busy held across SEND
        tx_busy = 1'b1;
        net_result = 4'd3;
        for (int i = 0; i < 784; i++) send_byte(8'(i), 2);
        repeat (3) @(negedge clk);
        chk("frame2 net_start count", 32'(ns_cnt), 32'd2);
        chk("frame2 mem_rst count", 32'(rst_cnt), 32'd2);
        tx0 = tx_cnt;
        @(negedge clk);
        net_done = 1'b1;
        repeat (500) @(negedge clk);
        chk("busy holds tx_rq", 32'(tx_cnt), 32'(tx0));
        tx_busy = 1'b0;
        f = cyc;
        wait_tx(tx0, "busy tx_rq seen");
        chk("busy tx timing", 32'(tx_cyc), 32'(f + 1));
        chk("busy tx_data", 32'(tx_last), 32'h33);
        repeat (5) @(negedge clk);
        chk("busy single tx_rq", 32'(tx_cnt), 32'(tx0 + 1));
        chk("overrun sticky", 32'(overrun), 32'd1);
        net_done = 1'b0;
        chk("mem_rst/mem_we exclusive", 32'(both_cnt), 32'd0);

        // Inter-byte timeout
        we0 = we_cnt;
        fe0 = fe_cnt;
        tx0 = tx_cnt;
        for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i), 5);
        wait_fe(fe0, "timeout frame_err seen");
        chk("timeout frame_err timing", 32'(fe_cyc), 32'(ev_cyc + 101));
        chk("timeout writes", 32'(we_cnt), 32'(we0 + 10));
        wait_tx(tx0, "timeout tx_rq seen");
        chk("timeout tx_data", 32'(tx_last), 32'h3F);
        chk("timeout tx timing", 32'(tx_cyc), 32'(fe_cyc + 2));
        chk("timeout last_result", 32'(last_result), 32'd3);
        we0 = we_cnt;
        send_byte(8'h11, 3);
        chk("restart mem_rst", 32'(last_rst_cyc), 32'(ev_cyc + 1));

        // rx_error together with a byte: abort wins
        for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i), 3);
        fe0 = fe_cnt;
        tx0 = tx_cnt;
        @(negedge clk);
        rx_data  = 8'hEE;
        rx_ready = 1'b1;
        rx_error = 1'b1;
        e = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_error = 1'b0;
        wait_fe(fe0, "rxerr frame_err seen");
        chk("rxerr frame_err timing", 32'(fe_cyc), 32'(e + 1));
        wait_tx(tx0, "rxerr tx_rq seen");
        chk("rxerr byte not written", 32'(we_cnt), 32'(we0 + 5));
        chk("rxerr tx_data", 32'(tx_last), 32'h3F);
        chk("rxerr last_result", 32'(last_result), 32'd3);

        // Reset in the middle of a load
        repeat (3) @(negedge clk);
        for (int i = 0; i < 300; i++) send_byte(8'(i), 1);
        @(negedge clk);
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        we0 = we_cnt;
        nRST = 1'b0;
        #1;
        chk("midreset last_result", 32'(last_result), 32'hF);
        chk("midreset mem_we", 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset no write", 32'(we_cnt), 32'(we0));
        chk("midreset overrun", 32'(overrun), 32'd0);
        r0 = rst_cnt;
        send_byte(8'h21, 3);
        chk("midreset mem_rst count", 32'(rst_cnt), 32'(r0 + 1));
        chk("midreset mem_rst timing", 32'(last_rst_cyc), 32'(ev_cyc + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Controls the image-in / digit-out loop around net_proc.
- Counts UART bytes into net_proc's external image memory.
- Starts inference once a full frame has been loaded.
- Queues the resulting ASCII digit to uart_tx.
- Replaces the ad-hoc byte counter and edge logic at the top level; adds an inter-byte timeout, error abort and overrun detection.

Parameters:
FRAME_LEN, 784, bytes per image (28x28 qi8 pixels); counter width $clog2(FRAME_LEN+1)
TIMEOUT_CYCLES, 1_000_000, max clk cycles between bytes inside a frame; 0 disables the timeout
ASCII_BASE, 8'h30, added to the result index to form the tx character
ERR_CHAR, 8'h3F, character sent when a frame is aborted ('?')

Ports:
clk  input  1  system clock
nRST  input  1  asynchronous active-low reset
rx_ready  input  1  uart_rx ready level; a byte is signalled by its rising edge
rx_data  input  8  uart_rx byte, valid when rx_ready is high
rx_error  input  1  uart_rx framing error level
mem_rst  output  1  one-cycle pulse that clears net_proc image memory address
mem_we  output  1  one-cycle write strobe into net_proc image memory
mem_wdata  output  8  byte written with mem_we
net_start  output  1  one-cycle inference start pulse
net_done  input  1  net_proc done level; the rising edge completes inference
net_result  input  4  net_proc argmax index, valid at net_done rising
tx_rq  output  1  one-cycle transmit request to uart_tx
tx_data  output  8  character for uart_tx, held until the next tx_rq
tx_busy  input  1  uart_tx busy
last_result  output  4  last inference index
overrun  output  1  sticky: a byte arrived while in RUN or SEND
frame_err  output  1  one-cycle pulse on timeout or rx_error abort

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, byte count=0, timeout counter=0.
  - All pulse outputs 0, mem_wdata=0, tx_data=0, overrun=0.
  - last_result=4'hF.
- All outputs are registered.
- Byte event: rx_ready high in cycle N and low in N-1.
- States: IDLE, LOAD, START, RUN, SEND, ABORT.
- IDLE:
  - On a byte event in cycle N: mem_rst=1 in N+1; mem_we=1 and mem_wdata=byte in N+2.
  - count becomes 1; go to LOAD.
- LOAD:
  - Each byte event produces mem_we exactly 2 cycles later and increments count.
  - The write for byte count==FRAME_LEN is followed by net_start=1 in the next cycle (START, one cycle), then RUN.
  - The timeout counter clears on every byte event and increments otherwise.
  - Reaching TIMEOUT_CYCLES → ABORT.
  - rx_error rising in LOAD → ABORT. The current byte is not written.
- RUN:
  - Waits for the net_done rising edge.
  - net_result is captured into last_result in the cycle after that edge; then SEND.
  - net_done edges outside RUN are ignored.
- SEND:
  - When tx_busy=0: tx_rq=1 for one cycle with tx_data=ASCII_BASE+last_result (8-bit add, no saturation); then IDLE.
  - If tx_busy stays high, remain in SEND indefinitely.
- ABORT:
  - frame_err=1 for one cycle; count=0.
  - Enters SEND with tx_data=ERR_CHAR; last_result unchanged.
- Byte events in RUN/SEND are dropped (no mem_we) and set overrun. overrun clears only on reset.
- Byte events in ABORT are dropped; overrun is not set.
- A byte event in the same cycle as a timeout expiry: the byte wins (counter clears).
- A byte event in the same cycle as rx_error rising: abort wins.
- mem_rst and mem_we are never high in the same cycle.
- net_start is never asserted outside START.

Decomposition:
- Package gusn_ctrl_pkg:
  - seq_state_t enum.
  - FRAME_LEN_MNIST=784.
  - ASCII_DIGIT0=8'h30, ASCII_QMARK=8'h3F.
- Sub-module rise_edge:
  - Registered level input.
  - Outputs pulse = in && !in_q.
  - Async nRST.
  - Used for rx_ready, rx_error and net_done.

Test Plan:
- Reset with nRST=0 mid-LOAD (count=300) → immediately state=IDLE, last_result=4'hF, no mem_we after release; the next byte gives mem_rst.
- 784 bytes 0x00..0x0F repeating, with gaps of 20 cycles → exactly one mem_rst, 784 mem_we with matching data, then net_start one cycle after the 784th write.
- net_done rises with net_result=7, tx_busy=0 → last_result=7, one tx_rq with tx_data=8'h37.
- TIMEOUT_CYCLES=100, send 10 bytes, then silence → frame_err at idle cycle 100, tx_rq with 8'h3F, last_result unchanged, next byte restarts with mem_rst.
- Byte during RUN → no mem_we, overrun=1 and stays 1 after the next frame completes.
- tx_busy held high for 500 cycles at SEND → tx_rq delayed until the cycle after tx_busy falls; exactly one pulse.
